stream_serializer: RTL and testbench

//   Transmit-side width converter for the valid/ready stream interface: accepts one
//   NUM_LANES*LANE_W word per upstream handshake, emits it as LANE_W beats, lane 0 first.

---
 rtl/stream_pkg.sv | 16 +
 rtl/stream_serializer.sv | 129 ++++++++++++
 tb/tb_stream_serializer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Shared types and defaults for the stream serializer.
// Lane index and count types below match the default 4 x 8 configuration.
package stream_pkg;

    localparam int DEF_NUM_LANES = 4;
    localparam int DEF_LANE_W    = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    typedef logic [$clog2(DEF_NUM_LANES)-1:0]   lane_idx_t;
    typedef logic [$clog2(DEF_NUM_LANES+1)-1:0] count_t;

endpackage

// File: rtl/stream_serializer.sv
// Wide word to LANE_W beat serializer, lane 0 first, last_o on final beat.
// Build option STREAM_SER_PARTIAL_EN adds count_i to send only a lane prefix.
module stream_serializer
    import stream_pkg::*;
#(
    parameter int  NUM_LANES = DEF_NUM_LANES,
    parameter int  LANE_W    = DEF_LANE_W,
    localparam int CNT_W     = $clog2(NUM_LANES + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic [NUM_LANES*LANE_W-1:0] data_i,
`ifdef STREAM_SER_PARTIAL_EN
    input  logic [CNT_W-1:0]            count_i,
`endif
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [LANE_W-1:0]           data_o,
    output logic                        last_o
);

    localparam int WORD_W = NUM_LANES * LANE_W;
    localparam int IDX_W  = $clog2(NUM_LANES);

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    ser_state_e          state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    idx_t                idx_q, idx_d;
    cnt_t                n_q, n_d;
    logic [LANE_W-1:0]   data_d;
    logic                last_d;
    cnt_t                n_in;
    logic                beat;
    logic                load;

    function automatic logic [LANE_W-1:0] lane_of(
        input logic [WORD_W-1:0] w,
        input idx_t              i
    );
        return w[int'(i)*LANE_W +: LANE_W];
    endfunction

    function automatic logic is_last(input idx_t i, input cnt_t n);
        return (cnt_t'(i) + cnt_t'(1)) == n;
    endfunction

`ifdef STREAM_SER_PARTIAL_EN
    assign n_in = (count_i > cnt_t'(NUM_LANES)) ? cnt_t'(NUM_LANES)
                                                : count_i;
`else
    assign n_in = cnt_t'(NUM_LANES);
`endif

    assign valid_o = (state_q == SEND);
    assign beat    = valid_o && ready_i;
    // Reload on the last beat is what keeps back-to-back words bubble-free.
    assign ready_o = (state_q == IDLE) ||
                     ((state_q == SEND) && last_o && ready_i);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        n_d     = n_q;
        data_d  = data_o;
        last_d  = last_o;
        load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    load = 1'b1;
                end
            end
            SEND: begin
                if (beat) begin
                    if (!last_o) begin
                        idx_d  = idx_q + idx_t'(1);
                        data_d = lane_of(word_q, idx_q + idx_t'(1));
                        last_d = is_last(idx_q + idx_t'(1), n_q);
                    end else if (valid_i) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        last_d  = 1'b0;
                    end
                end
            end
        endcase

        if (load) begin
            word_d = data_i;
            n_d    = n_in;
            idx_d  = '0;
            // A zero-lane word is consumed without producing beats.
            if (n_in == '0) begin
                state_d = IDLE;
                last_d  = 1'b0;
            end else begin
                state_d = SEND;
                data_d  = data_i[LANE_W-1:0];
                last_d  = (n_in == cnt_t'(1));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            n_q     <= '0;
            data_o  <= '0;
            last_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            data_o  <= data_d;
            last_o  <= last_d;
        end
    end

endmodule

// File: tb/tb_stream_serializer.sv
// Bench for stream_serializer: directed cases plus random traffic
// checked against a beat-queue model of the word-to-lane rules.
module tb_stream_serializer;

    localparam int NL = 4;
    localparam int LW = 8;
    localparam int CW = $clog2(NL + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_i;
    logic          ready_o;
    logic [31:0]   data_i;
    logic [CW-1:0] count_i;
    logic          valid_o;
    logic          ready_i;
    logic [7:0]    data_o;
    logic          last_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_data[$];
    logic       exp_last[$];

    logic       obs_valid;
    logic [7:0] obs_data;
    logic       obs_last;
    logic       obs_ready;

    logic       stall_pend;
    logic [7:0] stall_data;
    logic       stall_last;

    always #5 clk = ~clk;

    stream_serializer #(
        .NUM_LANES(NL),
        .LANE_W   (LW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_i (data_i),
`ifdef STREAM_SER_PARTIAL_EN
        .count_i(count_i),
`endif
        .valid_o(valid_o),
        .ready_i(ready_i),
        .data_o (data_o),
        .last_o (last_o)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int lanes_for(input logic [CW-1:0] c);
`ifdef STREAM_SER_PARTIAL_EN
        return (int'(c) > NL) ? NL : int'(c);
`else
        return NL;
`endif
    endfunction

    task automatic push_word(input logic [31:0] w, input int n);
        for (int k = 0; k < n; k++) begin
            exp_data.push_back(w[k*8 +: 8]);
            exp_last.push_back(k == n - 1);
        end
    endtask

    task automatic cycle(input logic v, input logic r, input logic [31:0] d,
                         input logic [CW-1:0] c);
        logic [7:0] ed;
        logic       el;
        @(negedge clk);
        valid_i = v;
        ready_i = r;
        data_i  = d;
        count_i = c;
        #1;
        obs_valid = valid_o;
        obs_data  = data_o;
        obs_last  = last_o;
        obs_ready = ready_o;
        if (stall_pend) begin
            check("stall_valid", 32'(valid_o), 32'd1);
            check("stall_data", 32'(data_o), 32'(stall_data));
            check("stall_last", 32'(last_o), 32'(stall_last));
        end
        stall_pend = valid_o && !ready_i;
        stall_data = data_o;
        stall_last = last_o;
        if (valid_o && ready_i) begin
            if (exp_data.size() == 0) begin
                check("beat_unexpected", 32'd1, 32'd0);
            end else begin
                ed = exp_data.pop_front();
                el = exp_last.pop_front();
                check("beat_data", 32'(data_o), 32'(ed));
                check("beat_last", 32'(last_o), 32'(el));
            end
        end
        if (valid_i && ready_o) begin
            push_word(data_i, lanes_for(count_i));
        end
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b1, 32'h0, CW'(NL));
    endtask

    logic [7:0] exp_seq[8];

    initial begin
        reset      = 1'b1;
        valid_i    = 1'b0;
        ready_i    = 1'b0;
        data_i     = '0;
        count_i    = CW'(NL);
        stall_pend = 1'b0;
        #1;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_last", 32'(last_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // single word, no back-pressure
        cycle(1'b1, 1'b1, 32'h44332211, CW'(NL));
        check("t1_accept", 32'(obs_ready), 32'd1);
        exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h0, 8'h0, 8'h0, 8'h0};
        for (int i = 0; i < 4; i++) begin
            idle_cycle();
            check("t1_valid", 32'(obs_valid), 32'd1);
            check("t1_data", 32'(obs_data), 32'(exp_seq[i]));
            check("t1_last", 32'(obs_last), 32'(i == 3));
        end
        idle_cycle();
        check("t1_done", 32'(obs_valid), 32'd0);

        // back-to-back words, no bubble
        cycle(1'b1, 1'b1, 32'hDDCCBBAA, CW'(NL));
        exp_seq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
        for (int i = 0; i < 8; i++) begin
            cycle(i < 4, 1'b1, 32'h04030201, CW'(NL));
            check("t2_valid", 32'(obs_valid), 32'd1);
            check("t2_data", 32'(obs_data), 32'(exp_seq[i]));
        end
        idle_cycle();
        check("t2_done", 32'(obs_valid), 32'd0);

        // back-pressure mid-word
        cycle(1'b1, 1'b1, 32'h44332211, CW'(NL));
        exp_seq = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h44, 8'h0, 8'h0};
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, !(i == 1 || i == 2), 32'h0, CW'(NL));
            check("t3_data", 32'(obs_data), 32'(exp_seq[i]));
            check("t3_last", 32'(obs_last), 32'(i == 5));
        end
        idle_cycle();
        check("t3_empty", 32'(exp_data.size()), 32'd0);

        // async reset after second beat
        cycle(1'b1, 1'b1, 32'h44332211, CW'(NL));
        idle_cycle();
        idle_cycle();
        @(negedge clk);
        valid_i = 1'b0;
        reset = 1'b1;
        #1;
        check("ar_valid", 32'(valid_o), 32'd0);
        check("ar_last", 32'(last_o), 32'd0);
        exp_data.delete();
        exp_last.delete();
        stall_pend = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ar_ready", 32'(ready_o), 32'd1);
        check("ar_valid_rel", 32'(valid_o), 32'd0);
        idle_cycle();
        check("ar_quiet", 32'(obs_valid), 32'd0);

`ifdef STREAM_SER_PARTIAL_EN
        cycle(1'b1, 1'b1, 32'h44332211, CW'(2));
        idle_cycle();
        check("p2_d0", 32'(obs_data), 32'h11);
        check("p2_l0", 32'(obs_last), 32'd0);
        idle_cycle();
        check("p2_d1", 32'(obs_data), 32'h22);
        check("p2_l1", 32'(obs_last), 32'd1);
        idle_cycle();
        check("p2_done", 32'(obs_valid), 32'd0);
        cycle(1'b1, 1'b1, 32'h44332211, CW'(0));
        idle_cycle();
        check("p0_valid", 32'(obs_valid), 32'd0);
        check("p0_ready", 32'(obs_ready), 32'd1);
`endif

        // random traffic against the beat queue
        for (int i = 0; i < 10000; i++) begin
            cycle(($urandom % 4) != 0, ($urandom % 3) != 0, $urandom,
                  CW'($urandom % (1 << CW)));
        end
        for (int i = 0; i < 12; i++) begin
            idle_cycle();
        end
        check("rand_drain", 32'(exp_data.size()), 32'd0);
        check("rand_idle", 32'(obs_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
